text_frame_sequencer: RTL and testbench
=======================================

// Module: text_frame_sequencer
// PURPOSE
//  Sequences one text frame: clears back buffer via fill_drawer, draws text line
//  symbol by symbol via symbol_drawer, then pulses frame_buffer swap. Owns the single
//  frame_buffer write port and muxes the two drawers onto it. Sits between the
//  expression/text store and the drawers.
// PARAMETERS
//  X0               0    x of first symbol (pixels)
//  Y0               200  y of first text row (pixels)
//  SYMBOL_PITCH     15   x advance per symbol
//  LINE_PITCH       20   y advance per wrapped row
//  SYMBOLS_PER_LINE 42   symbols per row before wrap (42*15 <= 640)
//  MAX_LEN          64   text store depth; sets text_len/addr widths (6 bits)
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   async active-low reset
//  start             in   1   1-cycle pulse: render a frame
//  ready             out  1   high when idle; low from cycle after accepted start
//  text_len          in   7   symbol count, sampled at start, 0..MAX_LEN
//  cursor_pos        in   6   cursor gap index, sampled at start
//  text_addr         out  6   text store read address
//  text_data         in   7   symbol code, valid 1 cycle after text_addr
//  fill_start        out  1   to fill_drawer.start
//  fill_ready        in   1   from fill_drawer.ready
//  sym_start         out  1   to symbol_drawer.start
//  sym_ready         in   1   from symbol_drawer.ready
//  sym_x/sym_y       out  10/9 symbol origin
//  sym_code          out  7   symbol code
//  sym_cursor_left   out  1   cursor bar at left edge of this symbol
//  sym_cursor_right  out  1   cursor bar at right edge of this symbol
//  fill_we/addr/data in   1/19/1  fill_drawer write port
//  sym_we/addr/data  in   1/19/1  symbol_drawer write port
//  fb_we/addr/data   out  1/19/1  frame_buffer write port
//  fb_swap           out  1   to frame_buffer.swap, 1-cycle pulse
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; ready=1; all strobes, text_addr, sym_*,
//   fb_* = 0; counters 0. Drawer started mid-operation is not aborted; sequencer
//   ignores its ready and any in-flight writes are dropped (fb_we=0 in IDLE).
//  FSM: IDLE -> FILL_GO -> FILL_WAIT -> [FETCH -> SYM_GO -> SYM_WAIT]* -> SWAP -> IDLE.
//  IDLE: start=1 latches text_len, cursor_pos; idx=0, col=0, x=X0, y=Y0; -> FILL_GO.
//   start while not IDLE ignored.
//  FILL_GO: fill_start=1 one cycle; -> FILL_WAIT.
//  FILL_WAIT: first cycle ignore fill_ready (drawer ready lags start by 1);
//   then on fill_ready=1 -> FETCH if len!=0 else SWAP.
//  FETCH: text_addr=idx; next cycle register text_data into sym_code -> SYM_GO.
//  SYM_GO: sym_start=1 one cycle; sym_x/y/code/cursor_* stable from SYM_GO until
//   sym_ready returns. cursor_left = (idx==cursor_pos);
//   cursor_right = (idx+1==cursor_pos). cursor_pos>len: no bars; cursor_pos==len>0:
//   right bar on last symbol only.
//  SYM_WAIT: ignore sym_ready first cycle; on sym_ready: idx++;
//   col==SYMBOLS_PER_LINE-1 ? (col=0, x=X0, y+=LINE_PITCH) : (col++, x+=SYMBOL_PITCH);
//   idx==len-1 -> SWAP else FETCH. y overflow past 479: clamp, not wrap.
//  SWAP: fb_swap=1 exactly one cycle; -> IDLE; ready=1 next cycle.
//  Write mux: FILL_GO/FILL_WAIT select fill_*; SYM_GO/SYM_WAIT select sym_*;
//   all other states fb_we=0, addr=0, data=0. Combinational, no added latency.
//  Latency, len=N, fill_drawer F cycles busy, symbol S cycles busy:
//   start->fb_swap = 2+F+N*(3+S) cycles approx.; exact per FSM above.
// STRUCTURE
//  Shared package/header: state encodings, SCREEN_W=640, SCREEN_H=480, FB_ADDR_W=19.
//  Single module; optional sub-module text_cursor_gen (x/y/col stepping + cursor
//  flags) if FSM exceeds ~250 lines.
// TESTING (bench with real fill_drawer, symbol_drawer, frame_buffer; dump as txt)
//  1 len=5 "hello", cursor_pos=1 -> 5 sym_start pulses at x=0,15,30,45,60 y=200;
//    'h' right bar, 'e' left bar; one fb_swap; ready returns high.
//  2 len=0 -> fill_start once, zero sym_start, fb_swap 1 cycle after fill_ready.
//  3 len=45 -> symbol 42 at x=0,y=220; symbol 44 at x=30,y=220; 45 sym_start total.
//  4 start pulsed again during SYM_WAIT -> ignored; exactly one fb_swap per frame.
//  5 rst_n low during SYM_WAIT -> ready=1, fb_we=0 immediately; new start renders
//    full frame correctly.
//  6 check fb_we never asserted in FETCH/SWAP/IDLE; mux source matches state.

Source files
------------

// File: rtl/text_frame_sequencer_pkg.sv
// Shared state encodings, screen geometry and bus widths for the text frame sequencer.
package text_frame_sequencer_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int FB_ADDR_W   = 19;
    localparam int MAX_LEN     = 64;
    localparam int TEXT_ADDR_W = $clog2(MAX_LEN);
    localparam int TEXT_LEN_W  = $clog2(MAX_LEN + 1);
    localparam int SYM_CODE_W  = 7;
    localparam int SYM_X_W     = $clog2(SCREEN_W);
    localparam int SYM_Y_W     = $clog2(SCREEN_H);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FILL_GO   = 3'd1;
    localparam logic [2:0] ST_FILL_WAIT = 3'd2;
    localparam logic [2:0] ST_FETCH     = 3'd3;
    localparam logic [2:0] ST_SYM_GO    = 3'd4;
    localparam logic [2:0] ST_SYM_WAIT  = 3'd5;
    localparam logic [2:0] ST_SWAP      = 3'd6;

    // Rows that would run off the bottom of the screen stick to the last line.
    function automatic logic [SYM_Y_W-1:0] clampRowY(input logic [SYM_Y_W:0] ySum);
        if (ySum > (SYM_Y_W + 1)'(SCREEN_H - 1))
            return SYM_Y_W'(SCREEN_H - 1);
        return ySum[SYM_Y_W-1:0];
    endfunction

endpackage

// File: rtl/text_frame_sequencer.sv
// Renders one text frame: clear via fill drawer, draw each symbol via symbol drawer,
// then swap buffers. Owns the frame buffer write port and muxes the drawers onto it.
module text_frame_sequencer
    import text_frame_sequencer_pkg::*;
#(
    parameter logic [SYM_X_W-1:0] X0               = 10'd0,
    parameter logic [SYM_Y_W-1:0] Y0               = 9'd200,
    parameter logic [SYM_X_W-1:0] SYMBOL_PITCH     = 10'd15,
    parameter logic [SYM_Y_W-1:0] LINE_PITCH       = 9'd20,
    parameter int                 SYMBOLS_PER_LINE = 42
)(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    output logic                   o_ready,
    input  logic [TEXT_LEN_W-1:0]  i_text_len,
    input  logic [TEXT_ADDR_W-1:0] i_cursor_pos,
    output logic [TEXT_ADDR_W-1:0] o_text_addr,
    input  logic [SYM_CODE_W-1:0]  i_text_data,
    output logic                   o_fill_start,
    input  logic                   i_fill_ready,
    output logic                   o_sym_start,
    input  logic                   i_sym_ready,
    output logic [SYM_X_W-1:0]     o_sym_x,
    output logic [SYM_Y_W-1:0]     o_sym_y,
    output logic [SYM_CODE_W-1:0]  o_sym_code,
    output logic                   o_sym_cursor_left,
    output logic                   o_sym_cursor_right,
    input  logic                   i_fill_we,
    input  logic [FB_ADDR_W-1:0]   i_fill_addr,
    input  logic                   i_fill_data,
    input  logic                   i_sym_we,
    input  logic [FB_ADDR_W-1:0]   i_sym_addr,
    input  logic                   i_sym_data,
    output logic                   o_fb_we,
    output logic [FB_ADDR_W-1:0]   o_fb_addr,
    output logic                   o_fb_data,
    output logic                   o_fb_swap
);

    localparam int               COL_W    = $clog2(SYMBOLS_PER_LINE);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SYMBOLS_PER_LINE - 1);

    logic [2:0]             r_state;
    logic [TEXT_LEN_W-1:0]  r_len;
    logic [TEXT_ADDR_W-1:0] r_cursor;
    logic [TEXT_LEN_W-1:0]  r_idx;
    logic [COL_W-1:0]       r_col;
    logic [TEXT_ADDR_W-1:0] r_textAddr;
    logic [SYM_X_W-1:0]     r_symX;
    logic [SYM_Y_W-1:0]     r_symY;
    logic [SYM_CODE_W-1:0]  r_symCode;
    logic                   r_curLeft;
    logic                   r_curRight;
    logic                   r_firstWait;
    logic                   r_fetchPhase;

    logic [TEXT_LEN_W-1:0]  w_idxNext;
    logic                   w_lastIdx;

    assign w_idxNext = r_idx + TEXT_LEN_W'(1);
    assign w_lastIdx = (r_idx == r_len - TEXT_LEN_W'(1));

    // Drawer ready lags its start by a cycle, so the first wait cycle never samples it.
    // The text store is synchronous, so FETCH spends one cycle on the address and one on the data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_cursor     <= '0;
            r_idx        <= '0;
            r_col        <= '0;
            r_textAddr   <= '0;
            r_symX       <= '0;
            r_symY       <= '0;
            r_symCode    <= '0;
            r_curLeft    <= 1'b0;
            r_curRight   <= 1'b0;
            r_firstWait  <= 1'b0;
            r_fetchPhase <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_len    <= i_text_len;
                        r_cursor <= i_cursor_pos;
                        r_idx    <= '0;
                        r_col    <= '0;
                        r_symX   <= X0;
                        r_symY   <= Y0;
                        r_state  <= ST_FILL_GO;
                    end
                end
                ST_FILL_GO: begin
                    r_firstWait <= 1'b1;
                    r_state     <= ST_FILL_WAIT;
                end
                ST_FILL_WAIT: begin
                    r_firstWait <= 1'b0;
                    if (!r_firstWait && i_fill_ready) begin
                        if (r_len != '0) begin
                            r_textAddr   <= '0;
                            r_fetchPhase <= 1'b0;
                            r_state      <= ST_FETCH;
                        end else begin
                            r_state <= ST_SWAP;
                        end
                    end
                end
                ST_FETCH: begin
                    r_fetchPhase <= 1'b1;
                    if (r_fetchPhase) begin
                        r_symCode  <= i_text_data;
                        r_curLeft  <= (r_idx == TEXT_LEN_W'(r_cursor));
                        r_curRight <= (w_idxNext == TEXT_LEN_W'(r_cursor));
                        r_state    <= ST_SYM_GO;
                    end
                end
                ST_SYM_GO: begin
                    r_firstWait <= 1'b1;
                    r_state     <= ST_SYM_WAIT;
                end
                ST_SYM_WAIT: begin
                    r_firstWait <= 1'b0;
                    if (!r_firstWait && i_sym_ready) begin
                        r_idx <= w_idxNext;
                        if (r_col == LAST_COL) begin
                            r_col  <= '0;
                            r_symX <= X0;
                            r_symY <= clampRowY({1'b0, r_symY} + {1'b0, LINE_PITCH});
                        end else begin
                            r_col  <= r_col + COL_W'(1);
                            r_symX <= r_symX + SYMBOL_PITCH;
                        end
                        if (w_lastIdx) begin
                            r_state <= ST_SWAP;
                        end else begin
                            r_textAddr   <= w_idxNext[TEXT_ADDR_W-1:0];
                            r_fetchPhase <= 1'b0;
                            r_state      <= ST_FETCH;
                        end
                    end
                end
                ST_SWAP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_fb_we   = 1'b0;
        o_fb_addr = '0;
        o_fb_data = 1'b0;
        case (r_state)
            ST_FILL_GO, ST_FILL_WAIT: begin
                o_fb_we   = i_fill_we;
                o_fb_addr = i_fill_addr;
                o_fb_data = i_fill_data;
            end
            ST_SYM_GO, ST_SYM_WAIT: begin
                o_fb_we   = i_sym_we;
                o_fb_addr = i_sym_addr;
                o_fb_data = i_sym_data;
            end
            default: ;
        endcase
    end

    assign o_ready            = (r_state == ST_IDLE);
    assign o_fill_start       = (r_state == ST_FILL_GO);
    assign o_sym_start        = (r_state == ST_SYM_GO);
    assign o_fb_swap          = (r_state == ST_SWAP);
    assign o_text_addr        = r_textAddr;
    assign o_sym_x            = r_symX;
    assign o_sym_y            = r_symY;
    assign o_sym_code         = r_symCode;
    assign o_sym_cursor_left  = r_curLeft;
    assign o_sym_cursor_right = r_curRight;

endmodule

// File: tb/tb_text_frame_sequencer.sv
// Directed bench for text_frame_sequencer with behavioural drawers and a synchronous text store.
module tb_text_frame_sequencer;

    localparam int          FILL_CYCLES = 6;
    localparam int          SYM_CYCLES  = 3;
    localparam logic [20:0] FILL_WORD   = {1'b1, 19'h2AAAA, 1'b1};
    localparam logic [20:0] SYM_WORD    = {1'b1, 19'h15555, 1'b0};
    localparam logic [20:0] NONE_WORD   = 21'd0;

    logic        clock = 1'b0;
    logic        rstN;
    logic        start;
    logic        ready;
    logic [6:0]  textLen;
    logic [5:0]  cursorPos;
    logic [5:0]  textAddr;
    logic [6:0]  textData = 7'd0;
    logic        fillStart;
    logic        fillReady;
    logic        symStart;
    logic        symReady;
    logic [9:0]  symX;
    logic [8:0]  symY;
    logic [6:0]  symCode;
    logic        symCurL;
    logic        symCurR;
    logic        fillWe;
    logic [18:0] fillAddr;
    logic        fillData;
    logic        symWe;
    logic [18:0] symAddr;
    logic        symData;
    logic        fbWe;
    logic [18:0] fbAddr;
    logic        fbData;
    logic        fbSwap;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    text_frame_sequencer dut (
        .i_clk              (clock),
        .i_rst_n            (rstN),
        .i_start            (start),
        .o_ready            (ready),
        .i_text_len         (textLen),
        .i_cursor_pos       (cursorPos),
        .o_text_addr        (textAddr),
        .i_text_data        (textData),
        .o_fill_start       (fillStart),
        .i_fill_ready       (fillReady),
        .o_sym_start        (symStart),
        .i_sym_ready        (symReady),
        .o_sym_x            (symX),
        .o_sym_y            (symY),
        .o_sym_code         (symCode),
        .o_sym_cursor_left  (symCurL),
        .o_sym_cursor_right (symCurR),
        .i_fill_we          (fillWe),
        .i_fill_addr        (fillAddr),
        .i_fill_data        (fillData),
        .i_sym_we           (symWe),
        .i_sym_addr         (symAddr),
        .i_sym_data         (symData),
        .o_fb_we            (fbWe),
        .o_fb_addr          (fbAddr),
        .o_fb_data          (fbData),
        .o_fb_swap          (fbSwap)
    );

    // Behavioural drawers: ready drops one cycle after start, then stays low for N cycles.
    // They ignore reset, like the real drawers, which are never aborted.
    logic [6:0] textMem [64];
    logic       fillStartD = 1'b0;
    logic       symStartD  = 1'b0;
    int         fillCnt    = 0;
    int         symCnt     = 0;

    always @(posedge clock) begin
        fillStartD <= fillStart;
        symStartD  <= symStart;
        if (fillStartD)       fillCnt <= FILL_CYCLES;
        else if (fillCnt > 0) fillCnt <= fillCnt - 1;
        if (symStartD)        symCnt <= SYM_CYCLES;
        else if (symCnt > 0)  symCnt <= symCnt - 1;
        textData <= textMem[textAddr];
    end

    assign fillReady = (fillCnt == 0);
    assign symReady  = (symCnt == 0);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Monitor: records every symbol request and checks which source owns the write port.
    logic [20:0] fbWord;
    logic [20:0] hist1 = '0;
    logic [20:0] hist2 = '0;
    int          symCount  = 0;
    int          fillCount = 0;
    int          swapCount = 0;
    logic [9:0]  recX [256];
    logic [8:0]  recY [256];
    logic [6:0]  recCode [256];
    logic [1:0]  recFlags [256];

    assign fbWord = {fbWe, fbAddr, fbData};

    always @(negedge clock) begin
        if (rstN) begin
            if (symStart) begin
                recX[symCount[7:0]]     = symX;
                recY[symCount[7:0]]     = symY;
                recCode[symCount[7:0]]  = symCode;
                recFlags[symCount[7:0]] = {symCurL, symCurR};
                checkOutput("fetchMuxA", 32'(hist1), 32'(NONE_WORD));
                checkOutput("fetchMuxB", 32'(hist2), 32'(NONE_WORD));
                checkOutput("symGoMux", 32'(fbWord), 32'(SYM_WORD));
                symCount++;
            end
            if (fillStart) begin
                fillCount++;
                checkOutput("fillGoMux", 32'(fbWord), 32'(FILL_WORD));
            end
            if (fbSwap) swapCount++;
            if (ready || fbSwap)       checkOutput("idleSwapMux", 32'(fbWord), 32'(NONE_WORD));
            if (fillCnt > 0)           checkOutput("fillWaitMux", 32'(fbWord), 32'(FILL_WORD));
            if (symCnt > 0 && !ready)  checkOutput("symWaitMux", 32'(fbWord), 32'(SYM_WORD));
            hist2 = hist1;
            hist1 = fbWord;
        end
    end

    // Pulses start for one cycle, then scrambles the sampled inputs to prove they were latched.
    task automatic applyStimulus(input logic [6:0] len, input logic [5:0] cur);
        textLen   = len;
        cursorPos = cur;
        start     = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        textLen   = 7'h7F;
        cursorPos = 6'h3F;
    endtask

    task automatic waitSwap(input string tag, output int cycles);
        cycles = 0;
        while (fbSwap !== 1'b1 && cycles < 3000) begin
            @(posedge clock); #1;
            cycles++;
        end
        checkOutput(tag, 32'(fbSwap), 32'd1);
        checkOutput("swapCycleMux", 32'(fbWord), 32'(NONE_WORD));
        @(posedge clock); #1;
        checkOutput("readyAfterSwap", 32'(ready), 32'd1);
        checkOutput("swapOneCycle", 32'(fbSwap), 32'd0);
    endtask

    // Returns one cycle after the next symbol request, i.e. in the first SYM_WAIT cycle.
    task automatic waitSymStart(input string tag);
        int k;
        k = 0;
        while (symStart !== 1'b1 && k < 500) begin
            @(posedge clock); #1;
            k++;
        end
        checkOutput(tag, 32'(symStart), 32'd1);
        @(posedge clock); #1;
    endtask

    logic [6:0] hello [5]   = '{7'h68, 7'h65, 7'h6c, 7'h6c, 7'h6f};
    logic [1:0] t1Flags [5] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00};

    initial begin
        int         n;
        int         symBase;
        int         fillBase;
        int         swapBase;
        logic [1:0] flagOr;

        rstN      = 1'b0;
        start     = 1'b0;
        textLen   = 7'd0;
        cursorPos = 6'd0;
        fillWe    = 1'b1;
        fillAddr  = 19'h2AAAA;
        fillData  = 1'b1;
        symWe     = 1'b1;
        symAddr   = 19'h15555;
        symData   = 1'b0;
        for (int i = 0; i < 64; i++) textMem[i] = 7'd0;
        for (int i = 0; i < 5; i++)  textMem[i] = hello[i];

        repeat (3) @(posedge clock); #1;
        checkOutput("rstReady", 32'(ready), 32'd1);
        checkOutput("rstFbWord", 32'(fbWord), 32'd0);
        checkOutput("rstStrobes", 32'({fillStart, symStart, fbSwap}), 32'd0);
        checkOutput("rstTextAddr", 32'(textAddr), 32'd0);
        checkOutput("rstSym", 32'({symX, symY, symCode, symCurL, symCurR}), 32'd0);
        rstN = 1'b1;
        @(posedge clock); #1;

        $display("[TB] frame 1: hello, cursor 1");
        symBase = symCount; fillBase = fillCount; swapBase = swapCount;
        applyStimulus(7'd5, 6'd1);
        checkOutput("t1ReadyLow", 32'(ready), 32'd0);
        checkOutput("t1FillStart", 32'(fillStart), 32'd1);
        waitSwap("t1Swap", n);
        checkOutput("t1Latency", 32'(n), 32'(3 + FILL_CYCLES + 5 * (5 + SYM_CYCLES)));
        checkOutput("t1SymCount", 32'(symCount - symBase), 32'd5);
        checkOutput("t1FillCount", 32'(fillCount - fillBase), 32'd1);
        checkOutput("t1SwapCount", 32'(swapCount - swapBase), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t1X", 32'(recX[8'(symBase + i)]), 32'(i * 15));
            checkOutput("t1Y", 32'(recY[8'(symBase + i)]), 32'd200);
            checkOutput("t1Code", 32'(recCode[8'(symBase + i)]), 32'(hello[i]));
            checkOutput("t1Flags", 32'(recFlags[8'(symBase + i)]), 32'(t1Flags[i]));
        end

        $display("[TB] frame 2: empty text");
        symBase = symCount; fillBase = fillCount; swapBase = swapCount;
        applyStimulus(7'd0, 6'd0);
        waitSwap("t2Swap", n);
        checkOutput("t2Latency", 32'(n), 32'(3 + FILL_CYCLES));
        checkOutput("t2SymCount", 32'(symCount - symBase), 32'd0);
        checkOutput("t2FillCount", 32'(fillCount - fillBase), 32'd1);
        checkOutput("t2SwapCount", 32'(swapCount - swapBase), 32'd1);

        $display("[TB] frame 3: 45 symbols with wrap, cursor beyond text");
        for (int i = 0; i < 64; i++) textMem[i] = 7'(i) ^ 7'h2A;
        symBase = symCount; fillBase = fillCount; swapBase = swapCount;
        applyStimulus(7'd45, 6'd63);
        waitSwap("t3Swap", n);
        checkOutput("t3Latency", 32'(n), 32'(3 + FILL_CYCLES + 45 * (5 + SYM_CYCLES)));
        checkOutput("t3SymCount", 32'(symCount - symBase), 32'd45);
        checkOutput("t3X41", 32'(recX[8'(symBase + 41)]), 32'd615);
        checkOutput("t3Y41", 32'(recY[8'(symBase + 41)]), 32'd200);
        checkOutput("t3X42", 32'(recX[8'(symBase + 42)]), 32'd0);
        checkOutput("t3Y42", 32'(recY[8'(symBase + 42)]), 32'd220);
        checkOutput("t3X44", 32'(recX[8'(symBase + 44)]), 32'd30);
        checkOutput("t3Y44", 32'(recY[8'(symBase + 44)]), 32'd220);
        checkOutput("t3Code0", 32'(recCode[8'(symBase)]), 32'h2A);
        checkOutput("t3Code44", 32'(recCode[8'(symBase + 44)]), 32'h06);
        flagOr = 2'b00;
        for (int i = 0; i < 45; i++) flagOr = flagOr | recFlags[8'(symBase + i)];
        checkOutput("t3NoBars", 32'(flagOr), 32'd0);

        $display("[TB] frame 4: restart attempt during symbol wait, cursor at end");
        symBase = symCount; fillBase = fillCount; swapBase = swapCount;
        applyStimulus(7'd3, 6'd3);
        waitSymStart("t4FirstSym");
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        waitSwap("t4Swap", n);
        repeat (20) @(posedge clock); #1;
        checkOutput("t4SwapCount", 32'(swapCount - swapBase), 32'd1);
        checkOutput("t4FillCount", 32'(fillCount - fillBase), 32'd1);
        checkOutput("t4SymCount", 32'(symCount - symBase), 32'd3);
        checkOutput("t4StillIdle", 32'(ready), 32'd1);
        checkOutput("t4Flags0", 32'(recFlags[8'(symBase)]), 32'd0);
        checkOutput("t4Flags1", 32'(recFlags[8'(symBase + 1)]), 32'd0);
        checkOutput("t4Flags2", 32'(recFlags[8'(symBase + 2)]), 32'b01);

        $display("[TB] frame 5: reset during symbol wait, then full frame");
        applyStimulus(7'd4, 6'd0);
        waitSymStart("t5FirstSym");
        waitSymStart("t5SecondSym");
        rstN = 1'b0;
        #1;
        checkOutput("t5RstReady", 32'(ready), 32'd1);
        checkOutput("t5RstFbWord", 32'(fbWord), 32'd0);
        checkOutput("t5RstStrobes", 32'({fillStart, symStart, fbSwap}), 32'd0);
        checkOutput("t5RstSym", 32'({symX, symY, textAddr}), 32'd0);
        repeat (2) @(posedge clock); #1;
        rstN = 1'b1;
        repeat (10) @(posedge clock); #1;
        symBase = symCount; fillBase = fillCount; swapBase = swapCount;
        applyStimulus(7'd4, 6'd0);
        waitSwap("t5Swap", n);
        checkOutput("t5Latency", 32'(n), 32'(3 + FILL_CYCLES + 4 * (5 + SYM_CYCLES)));
        checkOutput("t5SymCount", 32'(symCount - symBase), 32'd4);
        checkOutput("t5SwapCount", 32'(swapCount - swapBase), 32'd1);
        checkOutput("t5X3", 32'(recX[8'(symBase + 3)]), 32'd45);
        checkOutput("t5Y3", 32'(recY[8'(symBase + 3)]), 32'd200);
        checkOutput("t5Code1", 32'(recCode[8'(symBase + 1)]), 32'h2B);
        checkOutput("t5Code3", 32'(recCode[8'(symBase + 3)]), 32'h29);
        checkOutput("t5Flags0", 32'(recFlags[8'(symBase)]), 32'b10);
        checkOutput("t5Flags1", 32'(recFlags[8'(symBase + 1)]), 32'b00);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
